timer_pwm_generator: RTL and testbench

Free-running 32-bit timer/counter with two compare channels producing PWM waveforms (PWM_OUTA, PWM_OUTB) and a period interrupt. It sits as a peripheral on the system clock domain. Clock source, counting mode, period and compare values come from static configuration registers.

---
 rtl/timer_pwm_generator.sv | 126 ++++++++++++
 tb/tb_timer_pwm_generator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_pwm_generator.sv
// 32-bit timer with a selectable prescaler, normal, fast-PWM and phase-correct counting modes,
// two compare-driven PWM outputs and a single-cycle period interrupt.
module timer_pwm_generator (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  TMR_SRC,
  input  logic [1:0]  TMR_MODE,
  input  logic [31:0] TIMER_TOP,
  input  logic [31:0] PWM_CNTA,
  input  logic [31:0] PWM_CNTB,
  output logic        PWM_OUTA,
  output logic        PWM_OUTB,
  output logic        timer_interrupt
);

  typedef enum logic [1:0] {
    ModeNormal = 2'b00,
    ModeFast   = 2'b01,
    ModePhase  = 2'b10,
    ModeHalt   = 2'b11
  } mode_e;

  mode_e       mode_in;
  mode_e       mode_q, mode_d;
  logic [31:0] cnt_q, cnt_d;
  logic        up_q, up_d;
  logic [5:0]  pre_q, pre_d;
  logic        outa_q, outa_d;
  logic        outb_q, outb_d;
  logic        irq_q, irq_d;

  logic        tick;
  logic [31:0] cnt_nxt;
  logic        up_nxt;
  logic        wrap;

  assign mode_in = mode_e'(TMR_MODE);

  always_comb begin
    unique case (TMR_SRC)
      2'b00:   tick = 1'b0;
      2'b01:   tick = 1'b1;
      2'b10:   tick = (pre_q[2:0] == 3'd0);
      default: tick = (pre_q == 6'd0);
    endcase
  end

  // Count that would be taken on a tick; wrap marks the interrupt point of the period.
  always_comb begin
    cnt_nxt = cnt_q + 32'd1;
    up_nxt  = up_q;
    wrap    = 1'b0;
    if (mode_q == ModePhase) begin
      if (TIMER_TOP == '0) begin
        cnt_nxt = '0;
        up_nxt  = 1'b1;
        wrap    = 1'b1;
      end else if (up_q && (cnt_q < TIMER_TOP)) begin
        cnt_nxt = cnt_q + 32'd1;
      end else begin
        // Turning at TOP or already descending; reaching 0 flips back to up.
        wrap    = (cnt_q <= 32'd1);
        cnt_nxt = wrap ? '0 : (cnt_q - 32'd1);
        up_nxt  = wrap;
      end
    end else if (cnt_q >= TIMER_TOP) begin
      cnt_nxt = '0;
      wrap    = 1'b1;
    end
  end

  always_comb begin
    pre_d  = pre_q + 6'd1;
    mode_d = mode_in;
    cnt_d  = cnt_q;
    up_d   = up_q;
    outa_d = outa_q;
    outb_d = outb_q;
    irq_d  = 1'b0;
    if (mode_in != mode_q) begin
      cnt_d  = '0;
      up_d   = 1'b1;
      outa_d = 1'b0;
      outb_d = 1'b0;
    end else if (mode_q == ModeHalt) begin
      outa_d = 1'b0;
      outb_d = 1'b0;
    end else if (tick) begin
      cnt_d = cnt_nxt;
      up_d  = up_nxt;
      irq_d = wrap;
      if (mode_q == ModeNormal) begin
        outa_d = outa_q ^ (cnt_nxt == PWM_CNTA);
        outb_d = outb_q ^ (cnt_nxt == PWM_CNTB);
      end else begin
        outa_d = (cnt_nxt < PWM_CNTA);
        outb_d = (cnt_nxt < PWM_CNTB);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q <= mode_in;
      cnt_q  <= '0;
      up_q   <= 1'b1;
      pre_q  <= '0;
      outa_q <= 1'b0;
      outb_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      up_q   <= up_d;
      pre_q  <= pre_d;
      outa_q <= outa_d;
      outb_q <= outb_d;
      irq_q  <= irq_d;
    end
  end

  assign PWM_OUTA        = outa_q;
  assign PWM_OUTB        = outb_q;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_timer_pwm_generator.sv
// Scoreboard bench for timer_pwm_generator: a cycle model queues expected outputs per edge,
// plus duty/period measurements checked against fixed values.
module tb_timer_pwm_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  TMR_SRC;
  logic [1:0]  TMR_MODE;
  logic [31:0] TIMER_TOP;
  logic [31:0] PWM_CNTA;
  logic [31:0] PWM_CNTB;
  logic        PWM_OUTA;
  logic        PWM_OUTB;
  logic        timer_interrupt;

  timer_pwm_generator dut (
    .clk             (clk),
    .reset           (reset),
    .TMR_SRC         (TMR_SRC),
    .TMR_MODE        (TMR_MODE),
    .TIMER_TOP       (TIMER_TOP),
    .PWM_CNTA        (PWM_CNTA),
    .PWM_CNTB        (PWM_CNTB),
    .PWM_OUTA        (PWM_OUTA),
    .PWM_OUTB        (PWM_OUTB),
    .timer_interrupt (timer_interrupt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic a;
    logic b;
    logic irq;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  longint unsigned m_cnt;
  bit              m_up;
  int              m_pre;
  int              m_mode;
  bit              m_a, m_b, m_irq;

  // Measurements over a window
  int cyc, ha, hb, irq_n, last_irq, irq_period;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick;
    longint unsigned top;
    top = TIMER_TOP;
    if (!reset) begin
      m_cnt = 0; m_up = 1; m_pre = 0; m_a = 0; m_b = 0; m_irq = 0;
      m_mode = TMR_MODE;
      return;
    end
    tick = (TMR_SRC == 2'd1) || (TMR_SRC == 2'd2 && m_pre % 8 == 0) ||
           (TMR_SRC == 2'd3 && m_pre == 0);
    m_pre = (m_pre + 1) % 64;
    m_irq = 0;
    if (int'(TMR_MODE) != m_mode) begin
      m_mode = TMR_MODE; m_cnt = 0; m_up = 1; m_a = 0; m_b = 0;
    end else if (m_mode == 3) begin
      m_a = 0; m_b = 0;
    end else if (tick) begin
      if (m_mode == 2) begin
        if (top == 0) begin
          m_cnt = 0; m_up = 1; m_irq = 1;
        end else if (m_up && m_cnt < top) begin
          m_cnt++;
        end else begin
          if (m_cnt > 0) m_cnt--;
          m_up = 0;
          if (m_cnt == 0) begin m_irq = 1; m_up = 1; end
        end
      end else begin
        if (m_cnt >= top) begin m_cnt = 0; m_irq = 1; end
        else m_cnt++;
      end
      if (m_mode == 0) begin
        if (m_cnt == PWM_CNTA) m_a = !m_a;
        if (m_cnt == PWM_CNTB) m_b = !m_b;
      end else begin
        m_a = m_cnt < PWM_CNTA;
        m_b = m_cnt < PWM_CNTB;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e = '{a: m_a, b: m_b, irq: m_irq};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("sb_outa", PWM_OUTA, e.a);
    check_eq("sb_outb", PWM_OUTB, e.b);
    check_eq("sb_irq", timer_interrupt, e.irq);
    cyc++;
    ha += PWM_OUTA;
    hb += PWM_OUTB;
    if (timer_interrupt) begin
      if (last_irq >= 0) irq_period = cyc - last_irq;
      last_irq = cyc;
      irq_n++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_stats();
    cyc = 0; ha = 0; hb = 0; irq_n = 0; last_irq = -1; irq_period = 0;
  endtask

  initial begin
    logic a0, b0;
    reset = 1'b0; TMR_SRC = 2'd1; TMR_MODE = 2'd0;
    TIMER_TOP = 32'hFF; PWM_CNTA = 32'h50; PWM_CNTB = 32'hA0;
    m_cnt = 0; m_up = 1; m_pre = 0; m_mode = 0; m_a = 0; m_b = 0; m_irq = 0;
    clear_stats();

    // Reset held for two edges
    run(2);
    check_eq("rst_outa", PWM_OUTA, 0);
    check_eq("rst_outb", PWM_OUTB, 0);
    check_eq("rst_irq", timer_interrupt, 0);

    // Normal mode
    reset = 1'b1;
    clear_stats();
    run(79);
    check_eq("norm_a_before80", PWM_OUTA, 0);
    run(1);
    check_eq("norm_a_at80", PWM_OUTA, 1);
    run(80);
    check_eq("norm_b_at160", PWM_OUTB, 1);
    run(176);
    check_eq("norm_a_at336", PWM_OUTA, 0);
    run(300);
    check_eq("norm_irq_count", irq_n, 2);
    check_eq("norm_irq_period", irq_period, 256);

    // Fast PWM
    TMR_MODE = 2'd1;
    step();
    check_eq("sw_fast_outa", PWM_OUTA, 0);
    check_eq("sw_fast_outb", PWM_OUTB, 0);
    clear_stats();
    run(512);
    check_eq("fast_high_a", ha, 160);
    check_eq("fast_high_b", hb, 320);
    check_eq("fast_irq_count", irq_n, 2);
    check_eq("fast_irq_period", irq_period, 256);

    // Phase-correct PWM
    TMR_MODE = 2'd2;
    step();
    clear_stats();
    run(1020);
    check_eq("phase_high_a", ha, 318);
    check_eq("phase_irq_count", irq_n, 2);
    check_eq("phase_irq_period", irq_period, 510);

    // Reserved mode halts
    TMR_MODE = 2'd3;
    clear_stats();
    run(20);
    check_eq("halt_high_a", ha, 0);
    check_eq("halt_high_b", hb, 0);
    check_eq("halt_irq", irq_n, 0);

    // Reset pulse mid-count in fast PWM
    TMR_MODE = 2'd1;
    step();
    run(100);
    check_eq("mid_outa", PWM_OUTA, 0);
    check_eq("mid_outb", PWM_OUTB, 1);
    reset = 1'b0;
    step();
    check_eq("pulse_rst_outb", PWM_OUTB, 0);
    check_eq("pulse_rst_irq", timer_interrupt, 0);
    reset = 1'b1;

    // clk/8 prescale, TOP=3
    TMR_SRC = 2'd2; TIMER_TOP = 32'd3; PWM_CNTA = 32'd2;
    run(64);
    clear_stats();
    run(64);
    check_eq("div8_high_a", ha, 32);
    check_eq("div8_high_b", hb, 64);
    check_eq("div8_irq_count", irq_n, 2);
    check_eq("div8_irq_period", irq_period, 32);

    // Stopped source freezes everything
    run(5);
    TMR_SRC = 2'd0;
    a0 = PWM_OUTA; b0 = PWM_OUTB;
    clear_stats();
    run(50);
    check_eq("stop_irq", irq_n, 0);
    check_eq("stop_high_a", ha, 50 * int'(a0));
    check_eq("stop_high_b", hb, 50 * int'(b0));

    // TOP=0: interrupt every tick, outputs follow 0 < CNTx
    TMR_SRC = 2'd1; TIMER_TOP = 32'd0;
    run(2);
    clear_stats();
    run(10);
    check_eq("top0_irq_count", irq_n, 10);
    check_eq("top0_high_a", ha, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
